// File: rtl/q1_f_exhaustive_tester.sv
// q1_f_exhaustive_tester
//   Sweeps all 16 input combinations of the 4-input Q1 function onto an
//   external combinational block. It samples that block's F output once
//   per vector and compares the sample against a golden truth table.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is driven before it is sampled (>= 1)
//   GOLDEN_MASK    bit i is the expected F for vector index i
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   start, abort                begin a sweep (IDLE only) / cancel a running sweep
//   a_out..d_out                stimulus, {a,b,c,d} = vector index
//   f_in                        DUT response
//   busy, done                  sweep in progress / one-cycle completion pulse
//   pass, err_count, fail_map   results of the current or last sweep
//   first_fail_vec/_valid       index of the first mismatching vector
module q1_f_exhaustive_tester #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] GOLDEN_MASK   = 16'hF830
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        a_out,
    output logic        b_out,
    output logic        c_out,
    output logic        d_out,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] fail_map,
    output logic [3:0]  first_fail_vec,
    output logic        first_fail_valid
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    // Reject a zero settle time at elaboration.
    if (SETTLE_CYCLES == 0) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [4:0]       err_q, err_d;
    logic [15:0]      map_q, map_d;
    logic [3:0]       ffv_q, ffv_d;
    logic             ffval_q, ffval_d;
    logic             mismatch;

    assign mismatch = (f_in != GOLDEN_MASK[vec_q]);

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            map_q   <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            map_q   <= map_d;
            ffv_q   <= ffv_d;
            ffval_q <= ffval_d;
        end
    end

    // Next-state and result update.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        map_d   = map_q;
        ffv_d   = ffv_q;
        ffval_d = ffval_q;

        if (state_q != ST_IDLE && abort) begin
            // Cancel: partial error results are kept, pass is cleared.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            vec_d   = '0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        err_d   = '0;
                        map_d   = '0;
                        ffv_d   = '0;
                        ffval_d = 1'b0;
                        pass_d  = 1'b0;
                        vec_d   = '0;
                        cnt_d   = RELOAD;
                        busy_d  = 1'b1;
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_d        = err_q + 5'd1;
                        map_d[vec_q] = 1'b1;
                        if (!ffval_q) begin
                            ffv_d   = vec_q;
                            ffval_d = 1'b1;
                        end
                    end
                    if (vec_q != 4'd15) begin
                        vec_d   = vec_q + 4'd1;
                        cnt_d   = RELOAD;
                        state_d = ST_DRIVE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // err_q already includes the final vector's sample here.
                    done_d  = 1'b1;
                    pass_d  = (err_q == 5'd0);
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign a_out            = vec_q[3];
    assign b_out            = vec_q[2];
    assign c_out            = vec_q[1];
    assign d_out            = vec_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign fail_map         = map_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffval_q;

endmodule
